// File: rtl/uart_alu_pkg.sv
// Shared state encodings and sizing helpers for the UART/ALU frame controller.
// RX_CHK exists only when FRAME_CHECKSUM_EN is defined.
package uart_alu_pkg;

    localparam int STATE_W     = 3;
    localparam int SEQ_STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 3'd0,
        RX_OPND  = 3'd1,
        RX_OPC   = 3'd2,
`ifdef FRAME_CHECKSUM_EN
        RX_CHK   = 3'd3,
`endif
        ISSUE    = 3'd4,
        WAIT_RES = 3'd5,
        TX_RUN   = 3'd6
    } state_t;

    typedef enum logic [SEQ_STATE_W-1:0] {
        SEQ_IDLE = 2'd0,
        TX_SEND  = 2'd1,
        TX_WAIT  = 2'd2
    } seq_state_t;

    function automatic int calc_bpo(input int nb_data, input int nb_byte);
        return (nb_data + nb_byte - 1) / nb_byte;
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_byte_tx_seq.sv
// Byte sequencer: on i_load, sends N_BYTES bytes LSB-first through the UART
// transmitter with a start/busy handshake, then pulses o_done.
module uart_byte_tx_seq
    import uart_alu_pkg::*;
#(
    parameter int NB_BYTE = 8,
    parameter int N_BYTES = 2
)(
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_load,
    input  logic [N_BYTES*NB_BYTE-1:0] i_bytes,
    input  logic                       i_tx_busy,
    output logic                       o_tx_start,
    output logic [NB_BYTE-1:0]         o_tx_data,
    output logic                       o_done
);
    localparam int CW = cnt_width(N_BYTES);

    seq_state_t                 r_state;
    logic [CW-1:0]              r_cnt;
    logic [N_BYTES*NB_BYTE-1:0] r_shift;
    logic                       r_guard;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= SEQ_IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_guard    <= 1'b0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_done     <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_done     <= 1'b0;
            case (r_state)
                SEQ_IDLE: begin
                    if (i_load) begin
                        r_shift <= i_bytes;
                        r_cnt   <= '0;
                        r_state <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (!i_tx_busy) begin
                        o_tx_start <= 1'b1;
                        o_tx_data  <= r_shift[NB_BYTE-1:0];
                        r_shift    <= r_shift >> NB_BYTE;
                        r_guard    <= 1'b1;
                        r_state    <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    // The transmitter raises busy one cycle after start, so the first cycle is skipped.
                    if (r_guard) begin
                        r_guard <= 1'b0;
                    end else if (!i_tx_busy) begin
                        if (r_cnt == CW'(N_BYTES - 1)) begin
                            o_done  <= 1'b1;
                            r_state <= SEQ_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= TX_SEND;
                        end
                    end
                end
                default: r_state <= SEQ_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_alu_frame_ctrl.sv
// Frame controller between uart_rx/uart_tx and the ALU: collects operands and opcode,
// issues them, and returns the result. FRAME_CHECKSUM_EN adds XOR frame checksums.
module uart_alu_frame_ctrl
    import uart_alu_pkg::*;
#(
    parameter int NB_BYTE        = 8,
    parameter int NB_DATA        = 16,
    parameter int NB_OP          = 6,
    parameter int N_OPERANDS     = 2,
    parameter int ALU_LATENCY    = 1,
    parameter int TIMEOUT_CYCLES = 100000
)(
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_rx_done,
    input  logic [NB_BYTE-1:0]           i_rx_data,
    input  logic                         i_tx_busy,
    output logic                         o_tx_start,
    output logic [NB_BYTE-1:0]           o_tx_data,
    output logic [N_OPERANDS*NB_DATA-1:0] o_operands,
    output logic [NB_OP-1:0]             o_opcode,
    output logic                         o_alu_valid,
    input  logic [NB_DATA-1:0]           i_alu_result,
    output logic                         o_busy,
    output logic                         o_timeout_err,
    output logic                         o_overrun_err,
    output logic                         o_frame_err
);
    localparam int BPO = calc_bpo(NB_DATA, NB_BYTE);
    localparam int BW  = cnt_width(BPO);
    localparam int OW  = cnt_width(N_OPERANDS);
    localparam int TW  = cnt_width(TIMEOUT_CYCLES);
    localparam int LW  = cnt_width(ALU_LATENCY);
`ifdef FRAME_CHECKSUM_EN
    localparam int TXB = BPO + 1;
`else
    localparam int TXB = BPO;
`endif

    state_t                 r_state;
    logic [BW-1:0]          r_byte_cnt;
    logic [OW-1:0]          r_opnd_idx;
    logic [TW-1:0]          r_to_cnt;
    logic [LW-1:0]          r_lat_cnt;
    logic [BPO*NB_BYTE-1:0] r_opnd [N_OPERANDS];
    logic [TXB*NB_BYTE-1:0] r_tx_bytes;
    logic                   r_load;
    logic                   w_seq_done;
    logic                   w_last_byte;
    logic                   w_rx_state;
    logic                   w_busy_state;
    logic                   w_timeout;
    logic [BPO*NB_BYTE-1:0] w_res_ext;
`ifdef FRAME_CHECKSUM_EN
    logic [NB_BYTE-1:0]     r_chk;
    logic [NB_BYTE-1:0]     w_res_chk;

    always_comb begin
        w_res_chk = '0;
        for (int b = 0; b < BPO; b++) w_res_chk = w_res_chk ^ w_res_ext[b*NB_BYTE +: NB_BYTE];
    end
    assign w_rx_state = (r_state == RX_OPND) || (r_state == RX_OPC) || (r_state == RX_CHK);
`else
    assign w_rx_state = (r_state == RX_OPND) || (r_state == RX_OPC);
`endif

    assign w_res_ext    = (BPO*NB_BYTE)'(i_alu_result);
    assign w_busy_state = (r_state == ISSUE) || (r_state == WAIT_RES) || (r_state == TX_RUN);
    assign w_last_byte  = (r_byte_cnt == BW'(BPO - 1)) && (r_opnd_idx == OW'(N_OPERANDS - 1));
    assign w_timeout    = w_rx_state && !i_rx_done && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign o_busy       = (r_state != IDLE);

    // Bits of the top byte above NB_DATA are dropped here.
    for (genvar k = 0; k < N_OPERANDS; k++) begin : g_opnd
        assign o_operands[k*NB_DATA +: NB_DATA] = r_opnd[k][NB_DATA-1:0];
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= IDLE;
            r_byte_cnt    <= '0;
            r_opnd_idx    <= '0;
            r_to_cnt      <= '0;
            r_lat_cnt     <= '0;
            for (int k = 0; k < N_OPERANDS; k++) r_opnd[k] <= '0;
            r_tx_bytes    <= '0;
            r_load        <= 1'b0;
            o_opcode      <= '0;
            o_alu_valid   <= 1'b0;
            o_timeout_err <= 1'b0;
            o_overrun_err <= 1'b0;
            o_frame_err   <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            r_chk         <= '0;
`endif
        end else begin
            o_alu_valid   <= 1'b0;
            o_timeout_err <= 1'b0;
            o_overrun_err <= 1'b0;
            o_frame_err   <= 1'b0;
            r_load        <= 1'b0;
            if (w_rx_state && !i_rx_done) r_to_cnt <= r_to_cnt + 1'b1;
            if (w_busy_state && i_rx_done) o_overrun_err <= 1'b1;

            if (w_timeout) begin
                o_timeout_err <= 1'b1;
                r_byte_cnt    <= '0;
                r_opnd_idx    <= '0;
                r_to_cnt      <= '0;
                r_state       <= IDLE;
            end else begin
                case (r_state)
                    IDLE, RX_OPND: begin
                        if (i_rx_done) begin
                            r_opnd[r_opnd_idx][r_byte_cnt*NB_BYTE +: NB_BYTE] <= i_rx_data;
                            r_to_cnt <= '0;
`ifdef FRAME_CHECKSUM_EN
                            r_chk <= (r_state == IDLE) ? i_rx_data : (r_chk ^ i_rx_data);
`endif
                            if (w_last_byte) begin
                                r_byte_cnt <= '0;
                                r_opnd_idx <= '0;
                                r_state    <= RX_OPC;
                            end else if (r_byte_cnt == BW'(BPO - 1)) begin
                                r_byte_cnt <= '0;
                                r_opnd_idx <= r_opnd_idx + 1'b1;
                                r_state    <= RX_OPND;
                            end else begin
                                r_byte_cnt <= r_byte_cnt + 1'b1;
                                r_state    <= RX_OPND;
                            end
                        end
                    end
                    RX_OPC: begin
                        if (i_rx_done) begin
                            o_opcode <= i_rx_data[NB_OP-1:0];
                            r_to_cnt <= '0;
`ifdef FRAME_CHECKSUM_EN
                            r_chk    <= r_chk ^ i_rx_data;
                            r_state  <= RX_CHK;
`else
                            o_alu_valid <= 1'b1;
                            r_state     <= ISSUE;
`endif
                        end
                    end
`ifdef FRAME_CHECKSUM_EN
                    RX_CHK: begin
                        if (i_rx_done) begin
                            r_to_cnt <= '0;
                            if (i_rx_data == r_chk) begin
                                o_alu_valid <= 1'b1;
                                r_state     <= ISSUE;
                            end else begin
                                o_frame_err <= 1'b1;
                                r_state     <= IDLE;
                            end
                        end
                    end
`endif
                    ISSUE: begin
                        r_lat_cnt <= '0;
                        r_state   <= WAIT_RES;
                    end
                    WAIT_RES: begin
                        if (r_lat_cnt == LW'(ALU_LATENCY - 1)) begin
`ifdef FRAME_CHECKSUM_EN
                            r_tx_bytes <= {w_res_chk, w_res_ext};
`else
                            r_tx_bytes <= w_res_ext;
`endif
                            r_load  <= 1'b1;
                            r_state <= TX_RUN;
                        end else begin
                            r_lat_cnt <= r_lat_cnt + 1'b1;
                        end
                    end
                    TX_RUN: begin
                        if (w_seq_done) r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    uart_byte_tx_seq #(
        .NB_BYTE (NB_BYTE),
        .N_BYTES (TXB)
    ) u_tx_seq (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (r_load),
        .i_bytes    (r_tx_bytes),
        .i_tx_busy  (i_tx_busy),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .o_done     (w_seq_done)
    );

endmodule
